// File: rtl/status_led_testbus.sv
// status_led_testbus: stretched reset, per-LED off/on/blink/event-stretch drive and a registered test bus mux
module status_led_testbus #(
   parameter int NUM_LEDS    = 4,
   parameter int TB_WIDTH    = 8,
   parameter int NUM_TB_SRC  = 4,
   parameter int RST_STRETCH = 16,
   parameter int BLINK_DIV   = 24,
   parameter int PULSE_CYC   = 1024,
   parameter int SEL_W       = (NUM_TB_SRC > 1) ? $clog2(NUM_TB_SRC) : 1
) (
   input  logic                             i_CLK,
   input  logic                             i_RESET_n,
   input  logic [2*NUM_LEDS-1:0]            iv_LED_MODE,
   input  logic [NUM_LEDS-1:0]              iv_LED_EVENT,
   input  logic [SEL_W-1:0]                 iv_TB_SEL,
   input  logic [NUM_TB_SRC*TB_WIDTH-1:0]   iv_TB_SRC,
   output logic [TB_WIDTH-1:0]              ov_FPGA_TEST,
   output logic [NUM_LEDS-1:0]              ov_LED,
   output logic                             o_RESET_n
);
   localparam int CW = $clog2(PULSE_CYC + 1);
   logic [RST_STRETCH-1:0] rst_sr_q, rst_sr_d;
   logic [BLINK_DIV-1:0]   pre_q, pre_d;
   logic [CW-1:0]          cnt_q [NUM_LEDS];
   logic [CW-1:0]          cnt_d [NUM_LEDS];
   logic [NUM_LEDS-1:0]    led_q, led_d;
   logic [TB_WIDTH-1:0]    tb_q, tb_d;
   logic                   run;
   assign run          = rst_sr_q[RST_STRETCH-1];
   assign o_RESET_n    = run;
   assign ov_LED       = led_q;
   assign ov_FPGA_TEST = tb_q;
   // everything except the stretcher is held clear while the stretched reset is active
   always_comb begin
      rst_sr_d = {rst_sr_q[RST_STRETCH-2:0], 1'b1};
      pre_d    = run ? pre_q + BLINK_DIV'(1) : '0;
      tb_d     = '0;
      led_d    = '0;
      for (int s = 0; s < NUM_TB_SRC; s++)
         if (run && iv_TB_SEL == SEL_W'(s)) tb_d = iv_TB_SRC[s*TB_WIDTH +: TB_WIDTH];
      for (int k = 0; k < NUM_LEDS; k++) begin
         cnt_d[k] = (!run || iv_LED_MODE[2*k +: 2] != 2'b11) ? '0 :
                    iv_LED_EVENT[k] ? CW'(PULSE_CYC) :
                    (cnt_q[k] != '0) ? cnt_q[k] - CW'(1) : '0;
         led_d[k] = !run ? 1'b0 :
                    iv_LED_MODE[2*k+1] ? (iv_LED_MODE[2*k] ? (cnt_q[k] != '0) : pre_q[BLINK_DIV-1]) :
                    iv_LED_MODE[2*k];
      end
   end
   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         rst_sr_q <= '0;
         pre_q    <= '0;
         led_q    <= '0;
         tb_q     <= '0;
         for (int k = 0; k < NUM_LEDS; k++) cnt_q[k] <= '0;
      end else begin
         rst_sr_q <= rst_sr_d;
         pre_q    <= pre_d;
         led_q    <= led_d;
         tb_q     <= tb_d;
         for (int k = 0; k < NUM_LEDS; k++) cnt_q[k] <= cnt_d[k];
      end
   end
endmodule

// File: tb/tb_status_led_testbus.sv
// tb_status_led_testbus: scenario tasks with queued expectations for status_led_testbus
module tb_status_led_testbus;
   localparam int NL = 4, TW = 8, NS = 3, RS = 16, BD = 4, PC = 5, SW = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2*NL-1:0] mode = '0;
   logic [NL-1:0]   ev = '0;
   logic [SW-1:0]   sel = '0;
   logic [NS*TW-1:0] src = '0;
   logic [TW-1:0]   tb_out;
   logic [NL-1:0]   led;
   logic            rst_out;
   int checks = 0, errors = 0;
   logic [NL-1:0] led_exp_q[$];
   logic [TW-1:0] tb_exp_q[$];

   always #5 clk = ~clk;

   status_led_testbus #(
      .NUM_LEDS(NL), .TB_WIDTH(TW), .NUM_TB_SRC(NS),
      .RST_STRETCH(RS), .BLINK_DIV(BD), .PULSE_CYC(PC)
   ) dut (
      .i_CLK(clk), .i_RESET_n(rst_n), .iv_LED_MODE(mode), .iv_LED_EVENT(ev),
      .iv_TB_SEL(sel), .iv_TB_SRC(src), .ov_FPGA_TEST(tb_out), .ov_LED(led), .o_RESET_n(rst_out)
   );

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   // leaves the bench 1 time unit after the edge at which o_RESET_n rises
   task automatic do_reset();
      rst_n = 1'b0;
      edge_wait();
      edge_wait();
      rst_n = 1'b1;
      repeat (RS) edge_wait();
   endtask

   task automatic test_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (rst_out !== 1'b0) begin errors++; $display("FAIL reset_rst_out: got %b want 0", rst_out); end
      if (led !== '0) begin errors++; $display("FAIL reset_led: got %b want 0000", led); end
      if (tb_out !== '0) begin errors++; $display("FAIL reset_tb: got %h want 00", tb_out); end
      edge_wait();
      edge_wait();
      rst_n = 1'b1;
      for (int i = 1; i <= RS; i++) begin
         edge_wait();
         checks++;
         if (rst_out !== 1'(i == RS)) begin
            errors++; $display("FAIL stretch edge %0d: got %b want %b", i, rst_out, i == RS);
         end
      end
      rst_n = 1'b0;
      edge_wait();
      rst_n = 1'b1;
      repeat (8) edge_wait();
      rst_n = 1'b0;
      #1;
      checks++;
      if (rst_out !== 1'b0) begin errors++; $display("FAIL mid_stretch_abort: got %b want 0", rst_out); end
      edge_wait();
      rst_n = 1'b1;
      for (int i = 1; i <= RS; i++) begin
         edge_wait();
         checks++;
         if (rst_out !== 1'(i == RS)) begin
            errors++; $display("FAIL restretch edge %0d: got %b want %b", i, rst_out, i == RS);
         end
      end
   endtask

   task automatic test_modes();
      logic [NL-1:0] e, g;
      do_reset();
      mode = 8'b11_10_01_00;
      for (int n = 1; n <= 40; n++) begin
         ev = (n == 5) ? 4'b1000 : 4'b0000;
         e[0] = 1'b0;
         e[1] = 1'b1;
         e[2] = 1'(((n - 1) >> (BD - 1)) & 1);
         e[3] = 1'(n >= 6 && n <= 5 + PC);
         led_exp_q.push_back(e);
         edge_wait();
         g = led_exp_q.pop_front();
         checks++;
         if (led !== g) begin errors++; $display("FAIL modes n=%0d: got %b want %b", n, led, g); end
      end
      ev = '0;
   endtask

   task automatic test_event_stretch();
      logic [NL-1:0] e, g;
      do_reset();
      mode = 8'b11_00_00_00;
      for (int n = 1; n <= 30; n++) begin
         ev = (n == 2 || n == 5 || (n >= 15 && n <= 20)) ? 4'b1000 : 4'b0000;
         e = {1'((n >= 3 && n <= 5 + PC) || (n >= 16 && n <= 20 + PC)), 3'b000};
         led_exp_q.push_back(e);
         edge_wait();
         g = led_exp_q.pop_front();
         checks++;
         if (led !== g) begin errors++; $display("FAIL stretch n=%0d: got %b want %b", n, led, g); end
      end
      ev = '0;
   endtask

   task automatic test_mode_gating();
      logic [NL-1:0] e, g;
      do_reset();
      for (int n = 1; n <= 24; n++) begin
         mode = (n < 7 || n == 18) ? 8'b00_00_00_00 : 8'b11_00_00_00;
         ev = (n == 2) ? 4'b1111 : (n == 15) ? 4'b1000 : 4'b0000;
         e = {1'(n == 16 || n == 17), 3'b000};
         led_exp_q.push_back(e);
         edge_wait();
         g = led_exp_q.pop_front();
         checks++;
         if (led !== g) begin errors++; $display("FAIL gating n=%0d: got %b want %b", n, led, g); end
      end
      ev = '0;
   endtask

   task automatic test_back_to_back_tb();
      logic [TW-1:0] tab [4];
      logic [SW-1:0] seq [8];
      logic [TW-1:0] prev, e, g;
      tab = '{8'hA5, 8'h3C, 8'hF0, 8'h00};
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1};
      mode = '0;
      src = {8'hF0, 8'h3C, 8'hA5};
      prev = '0;
      for (int i = 0; i < 8; i++) begin
         sel = seq[i];
         #1;
         checks++;
         if (tb_out !== prev) begin errors++; $display("FAIL tb_latency i=%0d: got %h want %h", i, tb_out, prev); end
         e = tab[sel];
         tb_exp_q.push_back(e);
         edge_wait();
         g = tb_exp_q.pop_front();
         checks++;
         if (tb_out !== g) begin errors++; $display("FAIL tb_sel=%0d: got %h want %h", sel, tb_out, g); end
         prev = g;
      end
      src[15:8] = 8'h55;
      tb_exp_q.push_back(8'h55);
      edge_wait();
      g = tb_exp_q.pop_front();
      checks++;
      if (tb_out !== g) begin errors++; $display("FAIL tb_src_change: got %h want %h", tb_out, g); end
   endtask

   task automatic test_async_reset();
      do_reset();
      mode = 8'b11_10_01_00;
      sel = 2'd1;
      src = {8'hF0, 8'h3C, 8'hA5};
      for (int n = 1; n <= 10; n++) begin
         ev = (n == 8) ? 4'b1000 : 4'b0000;
         edge_wait();
      end
      checks += 2;
      if (led !== 4'b1110) begin errors++; $display("FAIL pre_async_led: got %b want 1110", led); end
      if (tb_out !== 8'h3C) begin errors++; $display("FAIL pre_async_tb: got %h want 3c", tb_out); end
      #2;
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (led !== '0) begin errors++; $display("FAIL async_led: got %b want 0000", led); end
      if (tb_out !== '0) begin errors++; $display("FAIL async_tb: got %h want 00", tb_out); end
      if (rst_out !== 1'b0) begin errors++; $display("FAIL async_rst_out: got %b want 0", rst_out); end
      ev = 4'b1000;
      edge_wait();
      rst_n = 1'b1;
      repeat (RS - 1) edge_wait();
      checks++;
      if (rst_out !== 1'b0) begin errors++; $display("FAIL async_restretch_early: got %b want 0", rst_out); end
      edge_wait();
      ev = '0;
      checks++;
      if (rst_out !== 1'b1) begin errors++; $display("FAIL async_restretch_done: got %b want 1", rst_out); end
      edge_wait();
      checks++;
      if (led !== 4'b0010) begin errors++; $display("FAIL events_in_reset: got %b want 0010", led); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_modes();
      test_event_stretch();
      test_mode_gating();
      test_back_to_back_tb();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/status_led_testbus.md
# status_led_testbus

Parametrised status-output block: it drives board LEDs and the FPGA test bus from a design top level. It generates a stretched, synchronously released reset for downstream logic. It also drives N LEDs, each with a selectable mode (off, on, blink, event-stretch), and muxes one of several internal debug words onto the test bus. It sits directly under the top level, between the board pins and the functional modules.

## Interface

- NUM_LEDS, 4, number of LED outputs
- TB_WIDTH, 8, test bus width
- NUM_TB_SRC, 4, number of test bus sources
- RST_STRETCH, 16, cycles of internal reset after i_RESET_n release (>=2)
- BLINK_DIV, 24, prescaler width; blink period 2^BLINK_DIV cycles
- PULSE_CYC, 1024, LED on-time in event-stretch mode (>=1)
- SEL_W, derived: clog2(NUM_TB_SRC), minimum 1

- i_CLK  in  1  single clock; all logic on rising edge
- i_RESET_n  in  1  reset, asynchronous, active-low
- iv_LED_MODE  in  2*NUM_LEDS  mode per LED; bits [2k+1:2k] for LED k; 00 off, 01 on, 10 blink, 11 event-stretch
- iv_LED_EVENT  in  NUM_LEDS  per-LED event, sampled each cycle, level-high = trigger
- iv_TB_SEL  in  SEL_W  test bus source index
- iv_TB_SRC  in  NUM_TB_SRC*TB_WIDTH  packed sources; source s is bits [s*TB_WIDTH +: TB_WIDTH]
- ov_FPGA_TEST  out  TB_WIDTH  registered test bus
- ov_LED  out  NUM_LEDS  registered LEDs, high = on
- o_RESET_n  out  1  stretched reset, active-low, asserts asynchronously, releases synchronously

## Operation

- Reset stretcher: RST_STRETCH-bit shift register, async-cleared by i_RESET_n low. Each edge shifts in 1. o_RESET_n = MSB.
- Internal reset = o_RESET_n. All other state is async-cleared by i_RESET_n and sync-cleared while o_RESET_n = 0.
- Prescaler: free-running BLINK_DIV-bit up-counter that wraps to 0. blink_phase = MSB.
- LED k next value:
  - mode 00: 0
  - mode 01: 1
  - mode 10: blink_phase
  - mode 11: (stretch_cnt[k] != 0)
- Stretch counter k has width clog2(PULSE_CYC+1).
  - In mode 11 with event high: load PULSE_CYC (retrigger reloads, even mid-count).
  - In mode 11 otherwise: decrement if nonzero, else hold 0.
  - In any other mode: clear to 0. Events are ignored.
- Test bus: ov_FPGA_TEST <= source[iv_TB_SEL] when iv_TB_SEL < NUM_TB_SRC, else all zeros.
- Mode, select and source changes take effect on the next registered output. There is no other filtering.

## Timing

- Reset values:
  - o_RESET_n = 0, ov_LED = 0, ov_FPGA_TEST = 0
  - prescaler = 0, all stretch counters = 0
- o_RESET_n rises on the RST_STRETCH-th rising edge at which i_RESET_n is sampled high.
- i_RESET_n low at any time, including mid-stretch or mid-blink, clears everything immediately with no clock required.
- Latency:
  - ov_LED: 1 cycle from iv_LED_MODE or blink_phase.
  - ov_FPGA_TEST: 1 cycle from iv_TB_SEL or iv_TB_SRC.
- Event-stretch, event high for one cycle at edge E: ov_LED high from edge E+1 through edge E+PULSE_CYC inclusive, i.e. exactly PULSE_CYC cycles. A held-high event keeps the LED on continuously.
- Mode change from 11 to another mode and back: counter restarts from 0. LED is off until the next event.
- Blink: ov_LED toggles every 2^(BLINK_DIV-1) cycles. First rise is 2^(BLINK_DIV-1)+1 cycles after o_RESET_n release.
- Events during o_RESET_n = 0 are discarded.

## Test plan

- Reset stretch (RST_STRETCH=16): release i_RESET_n at edge 0 -> o_RESET_n = 0 through edge 15, = 1 at edge 16. Reassert mid-stretch at edge 8 -> o_RESET_n stays 0 and the count restarts.
- Modes (NUM_LEDS=4, BLINK_DIV=4), iv_LED_MODE = 8'b11_10_01_00:
  - LED0 constant 0, LED1 constant 1.
  - LED2 toggles every 8 cycles.
  - LED3 follows events.
- Event stretch (PULSE_CYC=5): single-cycle event -> LED high exactly 5 cycles. Second event 3 cycles after the first -> LED high 8 cycles total.
- Mode-gated events: mode 00 with an event pulse -> LED stays 0. Switching to 11 without a new event -> LED stays 0.
- Test bus (NUM_TB_SRC=3, TB_WIDTH=8), sources 0xA5/0x3C/0xF0:
  - sel 0, 1, 2 -> 0xA5, 0x3C, 0xF0, each one cycle later.
  - sel 3 -> 0x00.
- Async reset mid-operation: assert i_RESET_n low while blinking and stretching -> ov_LED = 0, ov_FPGA_TEST = 0, o_RESET_n = 0 in the same cycle, before the next clock edge.
